// File: rtl/bb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bb_bus_pkg
// Purpose  : Shared field widths and FSM state encoding for the bit-serial
//            bus master and slave ports.
// Revision : 1.0 - initial release
// ============================================================================
package bb_bus_pkg;

   // Serial frame field widths: device select, local address, data byte.
   localparam int DEV_BITS   = 4;
   localparam int LADDR_BITS = 12;
   localparam int DATA_BITS  = 8;

   // Width of the per-phase bit counter; large enough for the longest phase.
   localparam int CNT_BITS   = 4;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_DEV_ADDR  = 4'd1,
      ST_ACK       = 4'd2,
      ST_ADDR      = 4'd3,
      ST_WR_DATA   = 4'd4,
      ST_WR_COMMIT = 4'd5,
      ST_RD_REQ    = 4'd6,
      ST_RD_WAIT   = 4'd7,
      ST_SPLIT     = 4'd8,
      ST_RD_DATA   = 4'd9
   } bb_state_e;

endpackage
`default_nettype wire

// File: rtl/bb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bb_timeout_ctr
// Purpose  : Loadable up-counter that saturates at LIMIT; o_hit is high while
//            the count has reached LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
module bb_timeout_ctr #(
   parameter int LIMIT = 63,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   output logic             o_hit
);

   localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

   logic [WIDTH-1:0] r_cnt;

   // Load has priority; otherwise count up and hold once LIMIT is reached.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc && (r_cnt < c_LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hit = (r_cnt >= c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/bb_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : bb_slave_port
// Purpose  : Bit-serial bus slave. Decodes a device-select nibble, a 12-bit
//            local address and (for writes) a data byte, then issues single
//            cycle memory strobes; read data is returned serially, with an
//            optional split indication for slow memories.
// Revision : 1.0 - initial release
// ============================================================================
module bb_slave_port
   import bb_bus_pkg::*;
#(
   parameter logic [3:0] DEVICE_ID    = 4'h0,
   parameter bit         SPLIT_EN     = 1'b0,
   parameter int         SPLIT_THRESH = 4,
   parameter int         TIMEOUT      = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  mode,
   input  logic                  wr_bus,
   input  logic                  master_valid,
   output logic                  slave_ready,
   output logic                  rd_bus,
   output logic                  slave_valid,
   input  logic                  master_ready,
   output logic                  ack,
   output logic                  split,
   output logic [LADDR_BITS-1:0] s_addr,
   output logic [DATA_BITS-1:0]  s_wr_data,
   output logic                  s_wr_en,
   output logic                  s_rd_en,
   input  logic [DATA_BITS-1:0]  s_rd_data,
   input  logic                  s_rd_valid
);

   // Counters fire on the cycle their count equals LIMIT, so LIMIT is one
   // less than the number of cycles that must elapse.
   localparam int c_TO_LIM = (TIMEOUT > 1) ? TIMEOUT - 1 : 0;
   localparam int c_TO_W   = (c_TO_LIM > 0) ? $clog2(c_TO_LIM + 1) : 1;
   localparam int c_SP_LIM = (SPLIT_THRESH > 1) ? SPLIT_THRESH - 1 : 0;
   localparam int c_SP_W   = (c_SP_LIM > 0) ? $clog2(c_SP_LIM + 1) : 1;

   localparam logic [CNT_BITS-1:0] c_DEV_LAST  = CNT_BITS'(DEV_BITS - 1);
   localparam logic [CNT_BITS-1:0] c_ADDR_LAST = CNT_BITS'(LADDR_BITS - 1);
   localparam logic [CNT_BITS-1:0] c_DATA_LAST = CNT_BITS'(DATA_BITS - 1);

   bb_state_e               r_state;
   bb_state_e               w_next;
   logic [CNT_BITS-1:0]     r_bitcnt;
   logic [DEV_BITS-1:0]     r_dev;
   logic                    r_mode;
   logic [LADDR_BITS-1:0]   r_addr;
   logic [DATA_BITS-1:0]    r_wdata;
   logic [DATA_BITS-1:0]    r_cap;

   logic w_in_hs;
   logic w_out_hs;
   logic w_hs;
   logic w_state_chg;
   logic w_to_hit;
   logic w_split_hit;
   logic w_dev_match;

   assign w_in_hs     = master_valid & slave_ready;
   assign w_out_hs    = slave_valid & master_ready;
   assign w_hs        = w_in_hs | w_out_hs;
   assign w_state_chg = (w_next != r_state);
   assign w_dev_match = (r_dev == DEVICE_ID);

   // Idle-handshake watchdog: restarts on every handshake and state entry.
   bb_timeout_ctr #(
      .LIMIT (c_TO_LIM),
      .WIDTH (c_TO_W)
   ) u_timeout (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_state_chg | w_hs),
      .i_load_val ({c_TO_W{1'b0}}),
      .i_inc      (1'b1),
      .o_hit      (w_to_hit)
   );

   generate
      if (SPLIT_EN) begin : g_split
         // Read-latency counter; restarts on entry to RD_WAIT.
         bb_timeout_ctr #(
            .LIMIT (c_SP_LIM),
            .WIDTH (c_SP_W)
         ) u_split_ctr (
            .clk        (clk),
            .rstn       (rstn),
            .i_load     (w_state_chg),
            .i_load_val ({c_SP_W{1'b0}}),
            .i_inc      (1'b1),
            .o_hit      (w_split_hit)
         );
      end else begin : g_no_split
         assign w_split_hit = 1'b0;
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (master_valid) w_next = ST_DEV_ADDR;
         end
         ST_DEV_ADDR: begin
            if (w_in_hs && (r_bitcnt == c_DEV_LAST)) w_next = ST_ACK;
            else if (!w_in_hs && w_to_hit)           w_next = ST_IDLE;
         end
         ST_ACK: begin
            w_next = w_dev_match ? ST_ADDR : ST_IDLE;
         end
         ST_ADDR: begin
            if (w_in_hs && (r_bitcnt == c_ADDR_LAST))
               w_next = r_mode ? ST_WR_DATA : ST_RD_REQ;
            else if (!w_in_hs && w_to_hit)
               w_next = ST_IDLE;
         end
         ST_WR_DATA: begin
            if (w_in_hs && (r_bitcnt == c_DATA_LAST)) w_next = ST_WR_COMMIT;
            else if (!w_in_hs && w_to_hit)            w_next = ST_IDLE;
         end
         ST_WR_COMMIT: w_next = ST_IDLE;
         ST_RD_REQ:    w_next = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (s_rd_valid)       w_next = ST_RD_DATA;
            else if (w_split_hit) w_next = ST_SPLIT;
         end
         ST_SPLIT: begin
            if (s_rd_valid) w_next = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (w_out_hs && (r_bitcnt == c_DATA_LAST)) w_next = ST_IDLE;
            else if (!w_out_hs && w_to_hit)            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Per-phase bit counter, restarted on every state entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bitcnt <= '0;
      end else if (w_state_chg) begin
         r_bitcnt <= '0;
      end else if (w_hs) begin
         r_bitcnt <= r_bitcnt + 1'b1;
      end
   end

   // Shift registers for the inbound frame fields and the read capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dev   <= '0;
         r_mode  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cap   <= '0;
      end else begin
         if ((r_state == ST_DEV_ADDR) && w_in_hs) begin
            r_dev <= {r_dev[DEV_BITS-2:0], wr_bus};
            if (r_bitcnt == '0) r_mode <= mode;
         end
         if ((r_state == ST_ADDR) && w_in_hs)
            r_addr <= {r_addr[LADDR_BITS-2:0], wr_bus};
         if ((r_state == ST_WR_DATA) && w_in_hs)
            r_wdata <= {r_wdata[DATA_BITS-2:0], wr_bus};
         if (((r_state == ST_RD_WAIT) || (r_state == ST_SPLIT)) && s_rd_valid)
            r_cap <= s_rd_data;
         else if ((r_state == ST_RD_DATA) && w_out_hs)
            r_cap <= {r_cap[DATA_BITS-2:0], 1'b0};
      end
   end

   assign slave_ready = (r_state == ST_DEV_ADDR) || (r_state == ST_ADDR) ||
                        (r_state == ST_WR_DATA);
   assign slave_valid = (r_state == ST_RD_DATA);
   assign rd_bus      = (r_state == ST_RD_DATA) & r_cap[DATA_BITS-1];
   assign ack         = (r_state == ST_ACK) & w_dev_match;
   assign split       = (r_state == ST_SPLIT);
   assign s_wr_en     = (r_state == ST_WR_COMMIT);
   assign s_rd_en     = (r_state == ST_RD_REQ);
   assign s_addr      = r_addr;
   assign s_wr_data   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_bb_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bb_slave_port
// Purpose  : Self-checking bench for bb_slave_port. Two instances share one
//            bus master; sel routes the master to instance A (DEVICE_ID=3,
//            no split) or B (DEVICE_ID=0, split enabled).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bb_slave_port;

   localparam int c_THRESH = 4;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic sel = 1'b0;

   logic       m_mode = 1'b0, m_wr_bus = 1'b0, m_valid = 1'b0, m_mready = 1'b0;
   logic       m_rd_valid = 1'b0;
   logic [7:0] m_rd_data = 8'h00;

   logic        a_ready, a_rd_bus, a_svalid, a_ack, a_split, a_wr_en, a_rd_en;
   logic [11:0] a_s_addr;
   logic [7:0]  a_s_wdata;
   logic        b_ready, b_rd_bus, b_svalid, b_ack, b_split, b_wr_en, b_rd_en;
   logic [11:0] b_s_addr;
   logic [7:0]  b_s_wdata;

   wire ready_mux  = sel ? b_ready  : a_ready;
   wire svalid_mux = sel ? b_svalid : a_svalid;
   wire rd_bus_mux = sel ? b_rd_bus : a_rd_bus;
   wire ack_mux    = sel ? b_ack    : a_ack;
   wire rd_en_mux  = sel ? b_rd_en  : a_rd_en;

   always #5 clk = ~clk;

   bb_slave_port #(.DEVICE_ID(4'h3), .SPLIT_EN(1'b0), .SPLIT_THRESH(c_THRESH), .TIMEOUT(64)) u_dut_a (
      .clk(clk), .rstn(rstn),
      .mode(m_mode & ~sel), .wr_bus(m_wr_bus & ~sel), .master_valid(m_valid & ~sel),
      .slave_ready(a_ready), .rd_bus(a_rd_bus), .slave_valid(a_svalid),
      .master_ready(m_mready & ~sel), .ack(a_ack), .split(a_split),
      .s_addr(a_s_addr), .s_wr_data(a_s_wdata), .s_wr_en(a_wr_en), .s_rd_en(a_rd_en),
      .s_rd_data(m_rd_data), .s_rd_valid(m_rd_valid & ~sel)
   );

   bb_slave_port #(.DEVICE_ID(4'h0), .SPLIT_EN(1'b1), .SPLIT_THRESH(c_THRESH), .TIMEOUT(64)) u_dut_b (
      .clk(clk), .rstn(rstn),
      .mode(m_mode & sel), .wr_bus(m_wr_bus & sel), .master_valid(m_valid & sel),
      .slave_ready(b_ready), .rd_bus(b_rd_bus), .slave_valid(b_svalid),
      .master_ready(m_mready & sel), .ack(b_ack), .split(b_split),
      .s_addr(b_s_addr), .s_wr_data(b_s_wdata), .s_wr_en(b_wr_en), .s_rd_en(b_rd_en),
      .s_rd_data(m_rd_data), .s_rd_valid(m_rd_valid & sel)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Strobe / split monitor, sampled away from the active edge.
   int          cyc = 0, wr_cnt = 0, rd_cnt = 0, split_cnt = 0, rd_cyc = 0, split_start = 0;
   logic [11:0] last_waddr = '0, last_raddr = '0;
   logic [7:0]  last_wdata = '0;
   bit          prev_split = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (a_wr_en) begin wr_cnt++; last_waddr = a_s_addr; last_wdata = a_s_wdata; end
      if (b_wr_en) begin wr_cnt++; last_waddr = b_s_addr; last_wdata = b_s_wdata; end
      if (a_rd_en) begin rd_cnt++; rd_cyc = cyc; last_raddr = a_s_addr; end
      if (b_rd_en) begin rd_cnt++; rd_cyc = cyc; last_raddr = b_s_addr; end
      if (a_split | b_split) begin
         split_cnt++;
         if (!prev_split) split_start = cyc;
      end
      prev_split = a_split | b_split;
   end

   // Cycles of split expected for a read answered lat cycles after s_rd_en.
   function automatic int exp_split(input bit split_en, input int lat);
      if (split_en && (lat > c_THRESH)) return lat - c_THRESH;
      return 0;
   endfunction

   // Push n bits (MSB first) through the valid/ready handshake with random gaps.
   task automatic send_bits(input logic [15:0] bits, input int n);
      int idx = 0;
      int budget = 0;
      while ((idx < n) && (budget < 200)) begin
         @(negedge clk);
         budget++;
         if ($urandom_range(0, 3) == 0) begin
            m_valid = 1'b0;
         end else begin
            m_valid  = 1'b1;
            m_wr_bus = bits[n-1-idx];
         end
         if (m_valid && ready_mux) idx++;
      end
      if (idx < n) chk("send_budget", 32'(idx), 32'(n));
   endtask

   task automatic do_write(input bit s, input logic [3:0] dev, input logic [11:0] addr,
                           input logic [7:0] data, input bit exp_ack);
      int wr0, rd0;
      sel = s; m_mode = 1'b1;
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_bits({12'd0, dev}, 4);
      @(negedge clk);
      chk("wr_ack", 32'(ack_mux), 32'(exp_ack));
      if (!exp_ack) m_valid = 1'b0;
      if (exp_ack) begin
         send_bits({4'd0, addr}, 12);
         send_bits({8'd0, data}, 8);
      end
      @(negedge clk); m_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wr_strobes", 32'(wr_cnt - wr0), 32'(exp_ack));
      chk("wr_no_rd", 32'(rd_cnt - rd0), 32'(0));
      chk("wr_idle_ready", 32'(ready_mux), 32'(0));
      if (exp_ack) begin
         chk("wr_addr", 32'(last_waddr), 32'(addr));
         chk("wr_data", 32'(last_wdata), 32'(data));
      end
   endtask

   task automatic do_read(input bit s, input logic [3:0] dev, input logic [11:0] addr,
                          input int lat, input logic [7:0] rdata, input bit exp_ack);
      int rd0, wr0, sp0, budget, n, esp;
      bit seen;
      logic [7:0] got;
      sel = s; m_mode = 1'b0;
      rd0 = rd_cnt; wr0 = wr_cnt; sp0 = split_cnt;
      send_bits({12'd0, dev}, 4);
      @(negedge clk);
      chk("rd_ack", 32'(ack_mux), 32'(exp_ack));
      if (!exp_ack) begin
         m_valid = 1'b0;
         repeat (4) @(negedge clk);
         chk("rd_nomatch_ready", 32'(ready_mux), 32'(0));
         chk("rd_nomatch_strobe", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'(0));
         return;
      end
      send_bits({4'd0, addr}, 12);
      seen = 1'b0; budget = 0;
      while (!seen && (budget < 8)) begin
         @(negedge clk);
         m_valid = 1'b0;
         budget++;
         if (rd_en_mux) seen = 1'b1;
      end
      chk("rd_en_seen", 32'(seen), 32'(1));
      repeat (lat) @(negedge clk);
      m_rd_data = rdata; m_rd_valid = 1'b1;
      n = 0; budget = 0; got = '0;
      while ((n < 8) && (budget < 100)) begin
         @(negedge clk);
         budget++;
         m_rd_valid = 1'b0;
         m_rd_data  = 8'($urandom);
         m_mready   = ($urandom_range(0, 3) != 0);
         if (m_mready && svalid_mux) begin
            got = {got[6:0], rd_bus_mux};
            n++;
         end
      end
      @(negedge clk); m_mready = 1'b0;
      repeat (2) @(negedge clk);
      esp = exp_split(s, lat);
      chk("rd_bits", 32'(n), 32'(8));
      chk("rd_byte", 32'(got), 32'(rdata));
      chk("rd_addr", 32'(last_raddr), 32'(addr));
      chk("rd_strobes", 32'(rd_cnt - rd0), 32'(1));
      chk("rd_no_wr", 32'(wr_cnt - wr0), 32'(0));
      chk("rd_split_cycles", 32'(split_cnt - sp0), 32'(esp));
      if (esp > 0) chk("rd_split_start", 32'(split_start - rd_cyc), 32'(c_THRESH + 1));
      chk("rd_done_valid", 32'(svalid_mux), 32'(0));
   endtask

   logic [7:0] mem [logic [11:0]];

   initial begin
      bit         s, match;
      logic [3:0] dev;
      logic [11:0] addr;
      logic [7:0] data;
      int         lat, wr0, rd0;

      // Reset state
      #3 rstn = 1'b0;
      #1;
      chk("rst_ready", 32'({a_ready, b_ready}), 32'(0));
      chk("rst_valid", 32'({a_svalid, b_svalid, a_rd_bus, b_rd_bus}), 32'(0));
      chk("rst_ctrl", 32'({a_ack, b_ack, a_split, b_split, a_wr_en, b_wr_en, a_rd_en, b_rd_en}), 32'(0));
      chk("rst_addr", 32'({a_s_addr, b_s_addr}), 32'(0));
      chk("rst_wdata", 32'({a_s_wdata, b_s_wdata}), 32'(0));
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Directed write, matching device
      do_write(1'b0, 4'h3, 12'hA5C, 8'hC3, 1'b1);
      // Directed read on device 0, data two cycles after the strobe
      do_read(1'b1, 4'h0, 12'h123, 2, 8'h96, 1'b1);
      // Device mismatch
      do_write(1'b0, 4'h5, 12'h111, 8'h22, 1'b0);
      // Slow read with split
      do_read(1'b1, 4'h0, 12'h7E1, 10, 8'h5A, 1'b1);
      // Slow read on the non-split instance
      do_read(1'b0, 4'h3, 12'h0F0, 10, 8'hA7, 1'b1);

      // Timeout after 6 address bits
      sel = 1'b0; m_mode = 1'b1;
      wr0 = wr_cnt; rd0 = rd_cnt;
      send_bits(16'h0003, 4);
      @(negedge clk);
      chk("to_ack", 32'(a_ack), 32'(1));
      send_bits(16'h0029, 6);
      repeat (64) begin @(negedge clk); m_valid = 1'b0; end
      chk("to_still_addr", 32'(a_ready), 32'(1));
      @(negedge clk);
      chk("to_idle", 32'(a_ready), 32'(0));
      chk("to_no_strobe", 32'(wr_cnt - wr0 + rd_cnt - rd0), 32'(0));
      do_write(1'b0, 4'h3, 12'h3B4, 8'h5E, 1'b1);

      // Reset in the middle of the write-data phase
      sel = 1'b0; m_mode = 1'b1;
      wr0 = wr_cnt;
      send_bits(16'h0003, 4);
      @(negedge clk);
      send_bits(16'h0A5C, 12);
      send_bits(16'h000C, 4);
      @(negedge clk);
      m_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("mrst_ready", 32'(a_ready), 32'(0));
      chk("mrst_outs", 32'({a_svalid, a_rd_bus, a_ack, a_split, a_wr_en, a_rd_en}), 32'(0));
      chk("mrst_addr", 32'(a_s_addr), 32'(0));
      chk("mrst_wdata", 32'(a_s_wdata), 32'(0));
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("mrst_no_wr", 32'(wr_cnt - wr0), 32'(0));
      do_write(1'b0, 4'h3, 12'hFFF, 8'h81, 1'b1);

      // Randomized mix against a small memory model
      for (int t = 0; t < 40; t++) begin
         s     = 1'($urandom_range(0, 1));
         match = ($urandom_range(0, 4) != 0);
         dev   = s ? 4'h0 : 4'h3;
         if (!match) dev = dev ^ 4'($urandom_range(1, 15));
         addr  = 12'h5A0 + 12'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            data = 8'($urandom);
            do_write(s, dev, addr, data, match);
            if (match) mem[addr] = data;
         end else begin
            lat  = $urandom_range(1, 9);
            data = mem.exists(addr) ? mem[addr] : 8'($urandom);
            do_read(s, dev, addr, lat, data, match);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
